// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic lab blocks: FSM state encoding,
// default operand width and the bit-counter width helper.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/full_subtractor_1b.sv
// One-bit full subtractor: d = a - b - bin, bout is the borrow out.
module full_subtractor_1b (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic a_xor_b;

    assign a_xor_b = a ^ b;
    assign d       = a_xor_b ^ bin;
    assign bout    = (~a & b) | (~a_xor_b & bin);

endmodule

// File: rtl/eight_bit_serial_subtractor.sv
// Bit-serial A - B - Bin, LSB first, one bit per clock behind a start/done handshake.
// Optional SUB_OVERFLOW_EN adds a signed-overflow flag Ovf published alongside Diff.
module eight_bit_serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_reg,  state_next;
    logic [CW-1:0]    cnt_reg,    cnt_next;
    logic [WIDTH-1:0] a_sh_reg,   a_sh_next;
    logic [WIDTH-1:0] b_sh_reg,   b_sh_next;
    logic [WIDTH-1:0] res_reg,    res_next;
    logic             br_reg,     br_next;
    logic             busy_reg,   busy_next;
    logic             done_reg,   done_next;
    logic [WIDTH-1:0] diff_reg,   diff_next;
    logic             borrow_reg, borrow_next;
`ifdef SUB_OVERFLOW_EN
    logic             ovf_reg,    ovf_next;
`endif

    logic             fs_d;
    logic             fs_bout;
    logic [WIDTH-1:0] res_shifted;

    full_subtractor_1b u_fs (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .bin  (br_reg),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // New bit enters at the MSB so the first (LSB) result bit ends at bit 0.
    assign res_shifted = {fs_d, res_reg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        a_sh_next   = a_sh_reg;
        b_sh_next   = b_sh_reg;
        res_next    = res_reg;
        br_next     = br_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        diff_next   = diff_reg;
        borrow_next = borrow_reg;
`ifdef SUB_OVERFLOW_EN
        ovf_next    = ovf_reg;
`endif

        case (state_reg)
            IDLE, DONE: begin
                busy_next = 1'b0;
                if (start) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                    a_sh_next  = A;
                    b_sh_next  = B;
                    res_next   = '0;
                    br_next    = Bin;
                    busy_next  = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end

            SHIFT: begin
                res_next  = res_shifted;
                a_sh_next = a_sh_reg >> 1;
                b_sh_next = b_sh_reg >> 1;
                br_next   = fs_bout;
                cnt_next  = cnt_reg + CW'(1);
                if (cnt_reg == LAST_BIT) begin
                    state_next  = DONE;
                    busy_next   = 1'b0;
                    done_next   = 1'b1;
                    diff_next   = res_shifted;
                    borrow_next = fs_bout;
`ifdef SUB_OVERFLOW_EN
                    // br_reg is the borrow into the MSB while the MSB is processed.
                    ovf_next    = br_reg ^ fs_bout;
`endif
                end
            end

            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_reg    <= '0;
            br_reg     <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            ovf_reg    <= 1'b0;
`endif
        end else begin
            cnt_reg    <= cnt_next;
            a_sh_reg   <= a_sh_next;
            b_sh_reg   <= b_sh_next;
            res_reg    <= res_next;
            br_reg     <= br_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            diff_reg   <= diff_next;
            borrow_reg <= borrow_next;
`ifdef SUB_OVERFLOW_EN
            ovf_reg    <= ovf_next;
`endif
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign Diff   = diff_reg;
    assign Borrow = borrow_reg;
`ifdef SUB_OVERFLOW_EN
    assign Ovf    = ovf_reg;
`endif

endmodule

// File: tb/tb_eight_bit_serial_subtractor.sv
// Randomized and directed bench for eight_bit_serial_subtractor against an
// arithmetic reference model. Define SUB_OVERFLOW_EN to also cover Ovf.
module tb_eight_bit_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       Bin;
    logic       busy;
    logic       done;
    logic [7:0] Diff;
    logic       Borrow;
`ifdef SUB_OVERFLOW_EN
    logic       Ovf;
`endif

    int checks = 0;
    int errors = 0;

    eight_bit_serial_subtractor #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .A      (A),
        .B      (B),
        .Bin    (Bin),
        .busy   (busy),
        .done   (done),
        .Diff   (Diff),
        .Borrow (Borrow)
`ifdef SUB_OVERFLOW_EN
        ,
        .Ovf    (Ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: plain integer arithmetic on the operands.
    function automatic logic [7:0] ref_diff(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int r;
        r = int'(a) - int'(b) - int'(bin);
        return r[7:0];
    endfunction

    function automatic logic ref_borrow(input logic [7:0] a, input logic [7:0] b, input logic bin);
        return int'(a) < (int'(b) + int'(bin));
    endfunction

    function automatic logic ref_ovf(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int s;
        s = int'($signed(a)) - int'($signed(b)) - int'(bin);
        return (s > 127) || (s < -128);
    endfunction

    function automatic logic get_ovf();
`ifdef SUB_OVERFLOW_EN
        return Ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Issue one request and wait for done; lat = 0 means no done within budget.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         output int lat, output int busy_cnt, output logic busy_at_done,
                         output logic [7:0] d, output logic br, output logic ov);
        A = a; B = b; Bin = bin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = 8'($urandom); B = 8'($urandom); Bin = 1'($urandom);
        lat = 0; busy_cnt = busy ? 1 : 0;
        busy_at_done = 1'b0; d = '0; br = 1'b0; ov = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k; busy_at_done = busy; d = Diff; br = Borrow; ov = get_ovf();
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (Diff !== 8'h00)  begin errors++; $display("FAIL reset_diff got %h want 00", Diff); end
        checks++; if (Borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow got %b want 0", Borrow); end
`ifdef SUB_OVERFLOW_EN
        checks++; if (Ovf !== 1'b0)    begin errors++; $display("FAIL reset_ovf got %b want 0", Ovf); end
`endif
        @(negedge clk); rst_n = 1'b1;
        $display("reset: busy=%b done=%b Diff=%h Borrow=%b", busy, done, Diff, Borrow);
    endtask

    task automatic run_vector(input string name, input logic [7:0] a, input logic [7:0] b, input logic bin);
        int lat, bc;
        logic bd, br, ov;
        logic [7:0] d;
        do_op(a, b, bin, lat, bc, bd, d, br, ov);
        $display("%s: A=%h B=%h Bin=%b -> Diff=%h Borrow=%b Ovf=%b lat=%0d", name, a, b, bin, d, br, ov, lat);
        checks++; if (lat !== 8) begin errors++; $display("FAIL %s_latency got %0d want 8", name, lat); end
        if (lat != 0) begin
            checks++; if (bc !== 8) begin errors++; $display("FAIL %s_busy_cycles got %0d want 8", name, bc); end
            checks++; if (bd !== 1'b0) begin errors++; $display("FAIL %s_busy_at_done got %b want 0", name, bd); end
            checks++; if (d !== ref_diff(a, b, bin)) begin errors++; $display("FAIL %s_diff got %h want %h", name, d, ref_diff(a, b, bin)); end
            checks++; if (br !== ref_borrow(a, b, bin)) begin errors++; $display("FAIL %s_borrow got %b want %b", name, br, ref_borrow(a, b, bin)); end
`ifdef SUB_OVERFLOW_EN
            checks++; if (ov !== ref_ovf(a, b, bin)) begin errors++; $display("FAIL %s_ovf got %b want %b", name, ov, ref_ovf(a, b, bin)); end
`endif
        end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got %b want 0", name, done); end
    endtask

    task automatic test_directed();
        run_vector("no_borrow",   8'h35, 8'h12, 1'b0);
        run_vector("borrow",      8'h01, 8'h02, 1'b0);
        run_vector("bin_only",    8'h00, 8'h00, 1'b1);
        run_vector("bin_nb",      8'hAF, 8'h01, 1'b1);
        run_vector("ovf_pos",     8'h80, 8'h01, 1'b0);
        run_vector("ovf_none",    8'h05, 8'h03, 1'b0);
        run_vector("all_ones",    8'hFF, 8'hFF, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            run_vector("random", 8'($urandom), 8'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_start_ignored();
        int dones = 0;
        int first_k = 0;
        logic [7:0] d = '0;
        A = 8'h10; B = 8'h01; Bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                dones++;
                if (dones == 1) begin first_k = k; d = Diff; end
            end
            if (k == 2) begin start = 1'b1; A = 8'h50; B = 8'h20; Bin = 1'b1; end
            if (k == 3) start = 1'b0;
        end
        $display("start_ignored: dones=%0d at=%0d Diff=%h", dones, first_k, d);
        checks++; if (dones !== 1)   begin errors++; $display("FAIL ignore_done_count got %0d want 1", dones); end
        checks++; if (first_k !== 8) begin errors++; $display("FAIL ignore_latency got %0d want 8", first_k); end
        checks++; if (d !== 8'h0F)   begin errors++; $display("FAIL ignore_diff got %h want 0f", d); end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        A = 8'h00; B = 8'h01; Bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("reset_mid: busy=%b done=%b Diff=%h Borrow=%b", busy, done, Diff, Borrow);
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)   begin errors++; $display("FAIL midrst_done got %b want 0", done); end
        checks++; if (Diff !== 8'h00)  begin errors++; $display("FAIL midrst_diff got %h want 00", Diff); end
        checks++; if (Borrow !== 1'b0) begin errors++; $display("FAIL midrst_borrow got %b want 0", Borrow); end
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL midrst_no_done got %0d active cycles want 0", dones); end
        run_vector("after_reset", 8'hC3, 8'h3C, 1'b0);
    endtask

    task automatic test_back_to_back();
        localparam int N = 4;
        logic [7:0] qa [N];
        logic [7:0] qb [N];
        logic       qc [N];
        int idx = 0;
        int last_t = 0;
        int t = 0;
        for (int i = 0; i < N; i++) begin
            qa[i] = 8'($urandom); qb[i] = 8'($urandom); qc[i] = 1'($urandom);
        end
        A = qa[0]; B = qb[0]; Bin = qc[0]; start = 1'b1;
        @(posedge clk);
        while (idx < N && t < 60) begin
            @(posedge clk); #1;
            t++;
            if (done) begin
                $display("back_to_back[%0d]: t=%0d Diff=%h Borrow=%b", idx, t, Diff, Borrow);
                checks++;
                if (t - last_t !== ((idx == 0) ? 8 : 9)) begin
                    errors++; $display("FAIL b2b_interval got %0d want %0d", t - last_t, (idx == 0) ? 8 : 9);
                end
                checks++;
                if (Diff !== ref_diff(qa[idx], qb[idx], qc[idx])) begin
                    errors++; $display("FAIL b2b_diff got %h want %h", Diff, ref_diff(qa[idx], qb[idx], qc[idx]));
                end
                checks++;
                if (Borrow !== ref_borrow(qa[idx], qb[idx], qc[idx])) begin
                    errors++; $display("FAIL b2b_borrow got %b want %b", Borrow, ref_borrow(qa[idx], qb[idx], qc[idx]));
                end
`ifdef SUB_OVERFLOW_EN
                checks++;
                if (Ovf !== ref_ovf(qa[idx], qb[idx], qc[idx])) begin
                    errors++; $display("FAIL b2b_ovf got %b want %b", Ovf, ref_ovf(qa[idx], qb[idx], qc[idx]));
                end
`endif
                last_t = t;
                idx++;
                if (idx < N) begin
                    A = qa[idx]; B = qb[idx]; Bin = qc[idx];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++; if (idx !== N) begin errors++; $display("FAIL b2b_count got %0d want %0d", idx, N); end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
